// File: rtl/pipe_scoreboard_pkg.sv
// Shared types and constants for the in-order pipeline hazard scoreboard.
// Slot entries carry a fixed-width rd so one typedef serves every NUM_REGS up to 256.
package pipe_scoreboard_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DEPTH    = 3;
    localparam int MAX_REG_W    = 8;

    // Operand source select: FWD_RF reads the register file, k+1 forwards from slot k.
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic                 is_load;
    } slot_t;

    function automatic int fwd_sel(input int slot_idx);
        return slot_idx + 1;
    endfunction

endpackage

// File: rtl/pipe_scoreboard_hazard_cmp.sv
// Compares one source operand against every tracked slot; returns stall request and forward select.
// Purely combinational, zero-cycle latency; no flow control of its own.
module hazard_cmp
    import pipe_scoreboard_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int FWD_EN = 0,
    parameter int REG_W  = 5,
    parameter int FW     = 3
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic              used,
    input  logic [REG_W-1:0]  idx,
    output logic              stall_req,
    output logic [FW-1:0]     fwd
);

    logic [DEPTH-1:0] match;
    logic             unused_slot_bits;

    // Only part of the slot state matters in each mode; fold the rest into a sink.
    assign unused_slot_bits = ^slots;

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = used && (idx != '0) && slots[k].valid
                       && (slots[k].rd == MAX_REG_W'(idx));
        end
    end

    always_comb begin
        stall_req = 1'b0;
        fwd       = FW'(FWD_RF);
        if (FWD_EN == 0) begin
            stall_req = |match[DEPTH-2:0];
        end else begin
            stall_req = match[0] & slots[0].is_load;
            // Walk oldest to youngest so the youngest producer wins.
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (match[k]) begin
                    fwd = FW'(fwd_sel(k));
                end
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Issue-stage scoreboard: tracks DEPTH in-flight writers, raises stall / forward selects combinationally.
// Backpressure is the stall output itself (holds PC and IF/ID); flush overrides stall and kills issue.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int FWD_EN   = 0,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs,
    input  logic [$clog2(NUM_REGS)-1:0] id_rt,
    input  logic                        id_rs_used,
    input  logic                        id_rt_used,
    input  logic [$clog2(NUM_REGS)-1:0] id_rd,
    input  logic                        id_wr,
    input  logic                        id_is_load,
    input  logic                        flush,
    output logic                        stall,
    output logic                        issue,
    output logic [$clog2(DEPTH):0]      fwd_a,
    output logic [$clog2(DEPTH):0]      fwd_b,
    output logic [CNT_W-1:0]            hazard_cnt
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int FW    = $clog2(DEPTH) + 1;

    slot_t [DEPTH-1:0] slots;
    logic              req_a;
    logic              req_b;
    logic [FW-1:0]     sel_a;
    logic [FW-1:0]     sel_b;

    hazard_cmp #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .REG_W(REG_W), .FW(FW)) u_cmp_rs (
        .slots     (slots),
        .used      (id_rs_used),
        .idx       (id_rs),
        .stall_req (req_a),
        .fwd       (sel_a)
    );

    hazard_cmp #(.DEPTH(DEPTH), .FWD_EN(FWD_EN), .REG_W(REG_W), .FW(FW)) u_cmp_rt (
        .slots     (slots),
        .used      (id_rt_used),
        .idx       (id_rt),
        .stall_req (req_b),
        .fwd       (sel_b)
    );

    always_comb begin
        stall = id_valid & ~flush & (req_a | req_b);
        issue = id_valid & ~stall & ~flush;
        fwd_a = FW'(FWD_RF);
        fwd_b = FW'(FWD_RF);
        if (id_valid && !stall) begin
            fwd_a = sel_a;
            fwd_b = sel_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else begin
            if (issue && id_wr && (id_rd != '0)) begin
                slots[0] <= '{valid: 1'b1, rd: MAX_REG_W'(id_rd), is_load: id_is_load};
            end else begin
                slots[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt <= '0;
        end else if (stall && (hazard_cnt != '1)) begin
            hazard_cnt <= hazard_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count; REG_W = clog2(NUM_REGS).
REQ-002 SHALL have parameter DEPTH, default 3, issued-instruction stages tracked (slot 0 = EX, slot DEPTH-1 = WB); legal 2..8.
REQ-003 SHALL have parameter FWD_EN, default 0, forwarding mode (0 = stall-only, 1 = forwarding with load-use stall).
REQ-004 SHALL have parameter CNT_W, default 16, hazard counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 id_rs, id_rt  in  REG_W each  source register indices.
REQ-009 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-010 id_rd  in  REG_W  destination index; id_wr  in  1  instruction writes id_rd.
REQ-011 id_is_load  in  1  instruction is a load.
REQ-012 flush  in  1  taken branch/jump; kills the ID instruction this cycle.
REQ-013 stall  out  1  hold PC and IF/ID, insert bubble.
REQ-014 issue  out  1  ID instruction enters slot 0 at next edge.
REQ-015 fwd_a, fwd_b  out  clog2(DEPTH)+1 each  operand source select: 0 = register file, k = slot k-1.
REQ-016 hazard_cnt  out  CNT_W  cumulative stall cycles.

Function
REQ-017 Each slot SHALL hold {valid, rd, is_load}; every clock all slots shift by one (slot k -> k+1), slot DEPTH-1 retires.
REQ-018 Slot 0 SHALL load {1, id_rd, id_is_load} when issue=1 and id_wr=1 and id_rd!=0; otherwise slot 0 SHALL become invalid (bubble).
REQ-019 A source SHALL match slot k when used, index !=0, slot k valid and slot rd equals index; register 0 never creates a hazard.
REQ-020 FWD_EN=0: stall SHALL assert when either source matches any slot 0..DEPTH-2 (register file is write-then-read, so slot DEPTH-1 is safe).
REQ-021 FWD_EN=1: stall SHALL assert only when a source matches slot 0 and slot 0 is_load=1 (one bubble).
REQ-022 FWD_EN=1, no stall: fwd_x SHALL equal k+1 for the youngest (lowest k) matching slot in 0..DEPTH-2, else 0; FWD_EN=0: fwd_x SHALL be 0 always.
REQ-023 stall, issue, fwd_x SHALL be combinational from current slots and ID inputs (zero-cycle latency); stall and fwd SHALL be 0 when id_valid=0.
REQ-024 issue SHALL equal id_valid & ~stall & ~flush.
REQ-025 flush SHALL take priority: stall=0, issue=0, slot 0 bubble; older slots unaffected.
REQ-026 hazard_cnt SHALL increment on every edge with stall=1 and saturate at all-ones without wrapping.
REQ-027 Back-to-back stalls SHALL release as soon as the producer shifts past the hazard window, with no extra bubble.

Reset
REQ-028 rst=1 SHALL immediately clear all slot valid bits and hazard_cnt, independent of clk.
REQ-029 During and after reset until new issue, stall=0 and fwd_a=fwd_b=0; reset mid-stall SHALL drop stall in the same cycle.

Structure
REQ-030 Shared package SHALL hold the slot entry typedef, fwd-select encoding constants (FWD_RF=0) and default DEPTH/NUM_REGS.
REQ-031 One sub-module, hazard_cmp, SHALL compare one source operand against all slots and return stall request and fwd select; instantiated twice (rs, rt).

Verification
REQ-032 FWD_EN=0: issue rd=4 writer, next cycle reader rs=4 -> stall=1 for 2 cycles, issue=1 on third, hazard_cnt=2.
REQ-033 FWD_EN=1: add rd=1, next cycle reader rs=1 -> stall=0, fwd_a=1; with one unrelated instruction between -> fwd_a=2.
REQ-034 FWD_EN=1: load rd=2, next cycle reader rt=2 -> stall=1 one cycle, then issue=1 with fwd_b=2.
REQ-035 Writer rd=0 then reader rs=0 -> stall=0, fwd_a=0, no slot entry created.
REQ-036 Hazard pending (stall=1) with flush=1 -> stall=0, issue=0, slot 0 bubble, hazard_cnt unchanged.
REQ-037 rst pulsed mid-stall off clock edge -> stall=0 and hazard_cnt=0 before next edge; reader then issues without stall.
